// File: rtl/rs232_tx.sv
// Buffers bytes in a FIFO and writes each one to an Avalon-MM UART once its status register reports TX ready.
// A write needs at least 3 cycles (query, send, idle). The bus is stalled by avm_waitrequest. Input is refused while the FIFO is full.
module rs232_tx #(
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [4:0] STATUS_ADDR = 5'd8,
   parameter logic [4:0] TX_ADDR     = 5'd4,
   parameter int         TX_OK_BIT   = 6
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   output logic [4:0]  avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [7:0]  i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_busy,
   output logic [15:0] o_tx_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, QUERY, SEND} state_t;

   state_t         state, state_nxt;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  occupancy;
   logic [15:0]    tx_count;
   logic           push, pop;
   logic           unused_readdata;

   assign unused_readdata = ^avm_readdata;

   assign o_ready    = (occupancy < CW'(FIFO_DEPTH));
   assign push       = i_valid & o_ready;
   assign pop        = (state == SEND) & ~avm_waitrequest;
   assign o_busy     = (occupancy != '0) | (state != IDLE);
   assign o_tx_count = tx_count;

   // Storage is not reset: the pointers alone define which entries are live.
   always_ff @(posedge avm_clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + CW'(1);
            2'b01:   occupancy <= occupancy - CW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // A failed status poll returns to IDLE, which creates the one-cycle gap before the next poll.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (occupancy != '0) begin
               state_nxt = QUERY;
            end
         end
         QUERY: begin
            if (!avm_waitrequest) begin
               state_nxt = avm_readdata[TX_OK_BIT] ? SEND : IDLE;
            end
         end
         SEND: begin
            if (!avm_waitrequest) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bus strobes are decoded from the next state, so they are registered and match the state exactly.
   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         tx_count      <= '0;
      end else begin
         avm_read  <= (state_nxt == QUERY);
         avm_write <= (state_nxt == SEND);
         if (state_nxt == QUERY) begin
            avm_address <= STATUS_ADDR;
         end else if (state_nxt == SEND) begin
            avm_address <= TX_ADDR;
         end
         if ((state != SEND) && (state_nxt == SEND)) begin
            avm_writedata <= {24'b0, mem[rd_ptr]};
         end
         if (pop) begin
            tx_count <= tx_count + 16'd1;
         end
      end
   end

endmodule
